formula_result_drain: RTL

FORMULA_RESULT_DRAIN -- requirements
Module: formula_result_drain

---
 rtl/formula_drain_pkg.sv | 12 +
 rtl/drain_fifo_with_count.sv | 55 +++++
 rtl/formula_result_drain.sv | 82 ++++++++
 3 files changed

// File: rtl/formula_drain_pkg.sv
// Shared sizing defaults and helpers for the formula result drain.
package formula_drain_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Counters need one extra bit so that a completely full buffer (== DEPTH) is representable.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/drain_fifo_with_count.sv
// Result buffer: power-of-two circular FIFO with an explicit occupancy count.
module drain_fifo_with_count
    import formula_drain_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                write_data,
    output logic [WIDTH-1:0]                read_data,
    output logic                            empty,
    output logic                            full,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign read_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= write_data;
    end

endmodule

// File: rtl/formula_result_drain.sv
// Credit-based drain for a fixed-latency formula pipe: issues arguments only while
// in-flight results plus buffered results fit in the result FIFO.
module formula_result_drain
    import formula_drain_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_vld_in,
    output logic             arg_rdy,
    output logic             issue,
    input  logic             res_vld,
    input  logic [WIDTH-1:0] res,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             err_overflow,
    output logic             err_unexpected
);

    localparam int unsigned CW    = count_width(DEPTH);
    localparam int unsigned SUM_W = CW + 1;

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    occupancy;
    logic [SUM_W-1:0] committed;
    logic             inflight_zero;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Credit uses registered counts only; a pop this cycle is returned next cycle.
    assign committed     = {1'b0, inflight} + {1'b0, occupancy};
    assign arg_rdy       = (committed < SUM_W'(DEPTH));
    assign issue         = arg_vld_in & arg_rdy;
    assign inflight_zero = (inflight == '0);
    assign push          = res_vld & ~full;
    assign out_vld       = ~empty;
    assign pop           = out_vld & out_rdy;

    drain_fifo_with_count #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .write_data (res),
        .read_data  (out_data),
        .empty      (empty),
        .full       (full),
        .count      (occupancy)
    );

    // An unexpected result must not wrap the in-flight counter below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, res_vld})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight_zero ? inflight : inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (res_vld & full)          err_overflow   <= 1'b1;
            if (res_vld & inflight_zero) err_unexpected <= 1'b1;
        end
    end

endmodule
